// File: rtl/prog_loader.sv
// Instruction-memory loader: takes a framed byte stream, writes big-endian 16-bit
// words to consecutive addresses and holds the CPU in reset until the checksum verifies.
module prog_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_HI, S_LO, S_WRITE, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t      state, state_nxt;
  logic [8:0]  remaining;
  logic [7:0]  addr;
  logic [7:0]  csum;
  logic [7:0]  hi_byte;
  logic        xfer;

  assign xfer = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    cpu_hold  = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_COUNT;
      S_COUNT: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_HI;
      end
      S_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_LO;
      end
      S_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        wr_en     = 1'b1;
        state_nxt = (remaining == 9'd1) ? S_CHECK : S_HI;
      end
      S_CHECK: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (in_data == csum) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start) state_nxt = S_COUNT;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) state_nxt = S_COUNT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // wr_addr/wr_data are captured with the low byte so they are already stable
  // for the whole WRITE cycle and keep their value afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      remaining <= 9'd0;
      addr      <= 8'd0;
      csum      <= 8'd0;
      hi_byte   <= 8'd0;
      wr_addr   <= BASE_ADDR;
      wr_data   <= 16'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_COUNT: if (xfer) begin
          remaining <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          csum      <= 8'd0;
          addr      <= BASE_ADDR;
        end
        S_HI: if (xfer) begin
          hi_byte <= in_data;
          csum    <= csum ^ in_data;
        end
        S_LO: if (xfer) begin
          wr_data <= {hi_byte, in_data};
          wr_addr <= addr;
          csum    <= csum ^ in_data;
        end
        S_WRITE: begin
          addr      <= addr + 8'd1;
          remaining <= remaining - 9'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (base 00 and 80) share one stream; each
// frame's writes are compared against words/addresses derived from the frame itself.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;

  logic        in_ready0, wr_en0, cpu_hold0, done0, err0;
  logic [7:0]  wr_addr0;
  logic [15:0] wr_data0;
  logic        in_ready1, wr_en1, cpu_hold1, done1, err1;
  logic [7:0]  wr_addr1;
  logic [15:0] wr_data1;

  prog_loader #(.BASE_ADDR(8'h00)) dut0 (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .cpu_hold(cpu_hold0), .done(done0), .err(err0)
  );

  prog_loader #(.BASE_ADDR(8'h80)) dut1 (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .cpu_hold(cpu_hold1), .done(done1), .err(err1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [23:0] q0[$];
  logic [23:0] q1[$];
  logic [15:0] words[256];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en0) q0.push_back({wr_addr0, wr_data0});
    if (wr_en1) q1.push_back({wr_addr1, wr_data1});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the transfer edge.
  task automatic send(input logic [7:0] b, input bit rnd, input bit pulse);
    int n;
    n = 0;
    if (rnd) repeat ($urandom_range(0, 2)) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    start    = pulse;
    while (!in_ready0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'(n), 32'd0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input int n, input bit bad, input bit rnd, input bit busy);
    logic [7:0] cs;
    int cyc_s;
    cs = 8'd0;
    q0.delete();
    q1.delete();
    start = 1'b1;
    cyc_s = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("hold_after_start0", 32'(cpu_hold0), 32'd1);
    chk("hold_after_start1", 32'(cpu_hold1), 32'd1);
    chk("done_after_start", 32'(done0), 32'd0);
    chk("err_after_start", 32'(err0), 32'd0);
    chk("ready_in_count", 32'(in_ready0), 32'd1);
    send(8'(n), rnd, 1'b0);
    for (int i = 0; i < n; i++) begin
      send(words[i][15:8], rnd, busy && (i == 0));
      send(words[i][7:0], rnd, 1'b0);
      cs = cs ^ words[i][15:8] ^ words[i][7:0];
    end
    send(bad ? (cs ^ 8'h01) : cs, rnd, 1'b0);
    in_valid = 1'b0;
    chk("done0", 32'(done0), 32'(!bad));
    chk("done1", 32'(done1), 32'(!bad));
    chk("err0", 32'(err0), 32'(bad));
    chk("err1", 32'(err1), 32'(bad));
    chk("cpu_hold0", 32'(cpu_hold0), 32'(bad));
    chk("cpu_hold1", 32'(cpu_hold1), 32'(bad));
    chk("ready_after_cs", 32'(in_ready0), 32'd0);
    if (!rnd) chk("load_cycles", 32'(cyc - cyc_s), 32'(3 * n + 3));
    chk("write_count0", 32'(q0.size()), 32'(n));
    chk("write_count1", 32'(q1.size()), 32'(n));
    for (int i = 0; i < n && i < q0.size() && i < q1.size(); i++) begin
      logic [7:0] a;
      a = i[7:0];
      chk("write0", 32'(q0[i]), 32'({a, words[i]}));
      chk("write1", 32'(q1[i]), 32'({a + 8'h80, words[i]}));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready0), 32'd0);
    chk("rst_wr_en", 32'(wr_en0), 32'd0);
    chk("rst_wr_addr0", 32'(wr_addr0), 32'h00);
    chk("rst_wr_addr1", 32'(wr_addr1), 32'h80);
    chk("rst_wr_data", 32'(wr_data0), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold0), 32'd1);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(in_ready0), 32'd0);

    // good load, then stray bytes in DONE must be refused
    words[0] = 16'h1234;
    words[1] = 16'hABCD;
    run_frame(2, 1'b0, 1'b0, 1'b0);
    in_data  = 8'h55;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("stray_no_write", 32'(q0.size()), 32'd2);
    chk("stray_done", 32'(done0), 32'd1);

    // bad checksum, then recovery with a good frame
    run_frame(2, 1'b1, 1'b0, 1'b0);
    run_frame(2, 1'b0, 1'b0, 1'b0);

    // back-pressure on a 4-word load
    for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
    run_frame(4, 1'b0, 1'b1, 1'b0);

    // N=0 encodes 256 words; addresses wrap
    for (int i = 0; i < 256; i++) words[i] = 16'($urandom);
    run_frame(256, 1'b0, 1'b0, 1'b0);
    chk("wrap_last_addr0", 32'(wr_addr0), 32'hFF);
    chk("wrap_last_addr1", 32'(wr_addr1), 32'h7F);

    // reset after the high byte of the second word
    for (int i = 0; i < 3; i++) words[i] = 16'($urandom);
    q0.delete();
    q1.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send(8'd3, 1'b0, 1'b0);
    send(words[0][15:8], 1'b0, 1'b0);
    send(words[0][7:0], 1'b0, 1'b0);
    send(words[1][15:8], 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready0), 32'd0);
    chk("mid_rst_wr_en", 32'(wr_en0), 32'd0);
    chk("mid_rst_wr_addr0", 32'(wr_addr0), 32'h00);
    chk("mid_rst_wr_addr1", 32'(wr_addr1), 32'h80);
    chk("mid_rst_wr_data", 32'(wr_data0), 32'd0);
    chk("mid_rst_cpu_hold", 32'(cpu_hold0), 32'd1);
    chk("mid_rst_done_err", 32'({done0, err0}), 32'd0);
    repeat (3) @(negedge clk);
    chk("mid_rst_writes", 32'(q0.size()), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    run_frame(3, 1'b0, 1'b0, 1'b0);

    // start pulse coinciding with an HI transfer is ignored
    for (int i = 0; i < 3; i++) words[i] = 16'($urandom);
    run_frame(3, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Instruction-memory loader: the writer side of the CPU's 8-bit-address / 16-bit-word instruction store, which the CPU only ever reads. It accepts a framed byte stream over a valid/ready handshake, assembles big-endian 16-bit instruction words, and writes them to consecutive instruction addresses. It holds the CPU in reset while loading and releases it only after a verified checksum.

## Interface
- BASE_ADDR, 8'h00, first instruction address written; matches the CPU PC reset address.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR; ignored while busy.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader can take a byte; a transfer occurs when in_valid && in_ready.
- wr_en  out  1  instruction-memory write strobe, one cycle per word.
- wr_addr  out  8  write address.
- wr_data  out  16  instruction word: {insMode, insShort[2:0], insLong[3:0], dataAddr[7:0]}.
- cpu_hold  out  1  drives the CPU active-low reset; 1 = hold the CPU in reset.
- done  out  1  level; the load completed with a good checksum.
- err  out  1  level; the load finished with a checksum mismatch.

## Operation
- Frame format: byte 0 = N, the word count (0 encodes 256). Then 2N data bytes, each word sent high byte first. Last byte = XOR of all 2N data bytes.
- States and transitions:
  - IDLE: start goes to COUNT.
  - COUNT: on transfer, latch N (9-bit count; 0 becomes 256), clear the checksum, set addr = BASE_ADDR, go to HI.
  - HI: on transfer, latch the high byte and XOR it into the checksum, go to LO.
  - LO: on transfer, latch the low byte and XOR it into the checksum, go to WRITE.
  - WRITE: assert wr_en for one cycle. Then addr = addr+1 (mod 256, wraps silently) and remaining = remaining-1. Go to CHECK if remaining reaches 0, otherwise go to HI.
  - CHECK: on transfer, compare the byte with the checksum. A match goes to DONE; a mismatch goes to ERR.
  - DONE: done=1 and cpu_hold=0. A start pulse goes to COUNT.
  - ERR: err=1 and cpu_hold=1. A start pulse goes to COUNT.
- in_ready=1 only in COUNT, HI, LO and CHECK; it is 0 in all other states.
- cpu_hold=1 in every state except DONE.
- done and err clear on the cycle that leaves DONE or ERR.
- Words already written stay in memory even if the checksum later fails; ERR keeps the CPU held in reset.
- wr_addr and wr_data are stable throughout the cycle in which wr_en is high. Outside that cycle they hold their last values.
- The loader never writes more than N words. Bytes arriving outside COUNT, HI, LO and CHECK are not accepted.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, in_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, cpu_hold=1, done=0, err=0, internal checksum and counters = 0.
- Reset asserted mid-load aborts immediately to these values. No partial write strobe may be issued.
- Latency: the LO byte is accepted at edge k, wr_en is high during cycle k+1, and HI is ready again at cycle k+2. So at most 2 of every 3 cycles accept a byte.
- Full load with in_valid held high: 1 (start) + 1 + 3N + 1 cycles until DONE; cpu_hold falls on the edge that enters DONE.
- A start pulse in the same cycle as a transfer in a busy state is ignored; the transfer proceeds.
- A start pulse in DONE re-asserts cpu_hold on the next edge.

## Test plan
- Good load: start; N=2, bytes 12 34 AB CD, checksum 12^34^AB^CD=40. Required: wr_en at addr 00 with data 1234, then at addr 01 with data ABCD. Then done=1, cpu_hold=0, err=0, and in_ready=0 after the checksum byte.
- Bad checksum: same frame with checksum 41. Required: both words written, err=1, done=0, cpu_hold stays 1. A new start followed by a good frame ends in done=1 with err=0.
- Back-pressure: in_valid toggles randomly across a 4-word load. Required: no byte lost or duplicated, exactly 4 wr_en pulses, correct addresses 00..03.
- N=0 with BASE_ADDR=8'h80: 512 data bytes plus checksum. Required: 256 writes, addr wraps from FF to 00 and ends at 7F, done=1.
- Mid-load reset: assert rst after the HI byte of word 1. Required: asynchronous return to all reset values and no wr_en pulse. After release, start plus a full frame loads correctly.
- Start while busy: pulse start during HI. Required: ignored, the frame completes normally, and exactly N writes occur.
